// File: rtl/arc4_key_sweep.sv
// Key-search sequencer: walks candidate keys through an external arc4 engine and
// accepts the first whose length-prefixed plaintext is printable. `ARC4_SWEEP_LOWER_EN narrows the byte set.
module arc4_key_sweep #(
  parameter int KEY_W    = 24,
  parameter int PT_AW    = 8,
  parameter int KEY_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             rdy,
  input  logic [KEY_W-1:0] start_key,
  input  logic             stop,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             arc4_en,
  input  logic             arc4_rdy,
  output logic [KEY_W-1:0] arc4_key,
  output logic [PT_AW-1:0] pt_addr,
  input  logic [7:0]       pt_rddata
);

  typedef enum logic [3:0] {
    S_IDLE, S_LAUNCH, S_GUARD, S_WAIT_ENG, S_RD_LEN, S_SCAN, S_NEXT, S_FOUND, S_DONE
  } state_t;

  state_t           state;
  logic [KEY_W-1:0] cur;
  logic [7:0]       len;
  logic [7:0]       cnt;
  logic             rd_vld;
  logic [KEY_W:0]   nxt;

  // one spare bit so a step past the top of the key space is visible as a carry
  assign nxt = {1'b0, cur} + (KEY_W+1)'(KEY_STEP);

  function automatic logic byte_ok(input logic [7:0] b);
`ifdef ARC4_SWEEP_LOWER_EN
    return (b >= 8'h61 && b <= 8'h7A) || b == 8'h20;
`else
    return b >= 8'h20 && b <= 8'h7E;
`endif
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rdy       <= 1'b1;
      key       <= '0;
      key_valid <= 1'b0;
      arc4_en   <= 1'b0;
      arc4_key  <= '0;
      pt_addr   <= '0;
      cur       <= '0;
      len       <= '0;
      cnt       <= '0;
      rd_vld    <= 1'b0;
    end else begin
      arc4_en <= 1'b0;
      case (state)
        S_IDLE: if (en) begin
          cur       <= start_key;
          key_valid <= 1'b0;
          rdy       <= 1'b0;
          state     <= S_LAUNCH;
        end
        S_LAUNCH: if (arc4_rdy) begin
          arc4_key <= cur;
          arc4_en  <= 1'b1;
          state    <= S_GUARD;
        end
        // engine drops rdy one cycle after en; don't mistake the stale high for completion
        S_GUARD: state <= S_WAIT_ENG;
        S_WAIT_ENG: if (arc4_rdy) begin
          pt_addr <= '0;
          rd_vld  <= 1'b0;
          state   <= S_RD_LEN;
        end
        S_RD_LEN: begin
          if (!rd_vld) rd_vld <= 1'b1;
          else begin
            len    <= pt_rddata;
            rd_vld <= 1'b0;
            if (pt_rddata == 8'h00) state <= S_FOUND;
            else begin
              pt_addr <= PT_AW'(1);
              cnt     <= 8'd1;
              state   <= S_SCAN;
            end
          end
        end
        // address runs one ahead of the byte being checked; rd_vld marks the first-read bubble
        S_SCAN: begin
          if (!rd_vld) begin
            rd_vld  <= 1'b1;
            pt_addr <= pt_addr + PT_AW'(1);
          end else if (!byte_ok(pt_rddata)) state <= S_NEXT;
          else if (cnt == len) state <= S_FOUND;
          else begin
            cnt     <= cnt + 8'd1;
            pt_addr <= pt_addr + PT_AW'(1);
          end
        end
        S_NEXT: begin
          if (stop || nxt[KEY_W]) state <= S_DONE;
          else begin
            cur   <= nxt[KEY_W-1:0];
            state <= S_LAUNCH;
          end
        end
        S_FOUND: begin
          key       <= cur;
          key_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          rdy   <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_key_sweep.sv
// Scoreboard bench for arc4_key_sweep: behavioural arc4 engine + key-indexed plaintext table,
// expected sweep results computed from the acceptance rules and checked on each completion.
module tb_arc4_key_sweep;
  localparam int KW    = 5;
  localparam int STEP  = 3;
  localparam int LIMIT = 31;

  logic          clk = 1'b0;
  logic          rst, en, rdy, stop, key_valid, arc4_en, arc4_rdy;
  logic [KW-1:0] start_key, key, arc4_key, eng_key;
  logic [7:0]    pt_addr, pt_rddata;
  logic [7:0]    pt_tab [0:LIMIT][0:255];
  int            eng_cnt;

  typedef struct {
    bit            valid;
    logic [KW-1:0] key;
    int            pulses;
  } exp_t;
  exp_t sb[$];
  int   tests = 0, fails = 0;

  always #5 clk = ~clk;

  arc4_key_sweep #(.KEY_W(KW), .PT_AW(8), .KEY_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .start_key(start_key), .stop(stop),
    .key(key), .key_valid(key_valid), .arc4_en(arc4_en), .arc4_rdy(arc4_rdy),
    .arc4_key(arc4_key), .pt_addr(pt_addr), .pt_rddata(pt_rddata)
  );

  // engine: rdy falls the cycle after en, rises 20 cycles later; plaintext is a function of the key
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      arc4_rdy <= 1'b1;
      eng_cnt  <= 0;
      eng_key  <= '0;
    end else if (arc4_en && arc4_rdy) begin
      eng_key  <= arc4_key;
      arc4_rdy <= 1'b0;
      eng_cnt  <= 20;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) arc4_rdy <= 1'b1;
    end
  end

  always @(posedge clk) pt_rddata <= pt_tab[eng_key][pt_addr];

  function automatic bit ok_byte(input logic [7:0] b);
`ifdef ARC4_SWEEP_LOWER_EN
    return (b >= 8'h61 && b <= 8'h7A) || b == 8'h20;
`else
    return b >= 8'h20 && b <= 8'h7E;
`endif
  endfunction

  function automatic bit key_ok(input int k);
    int l = pt_tab[k][0];
    for (int i = 1; i <= l; i++) if (!ok_byte(pt_tab[k][i])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic exp_t model(input int start, input bit stop_m);
    exp_t e;
    int k = start;
    e.valid = 1'b0; e.key = '0; e.pulses = 0;
    while (1) begin
      e.pulses++;
      if (key_ok(k)) begin
        e.valid = 1'b1; e.key = KW'(k);
        return e;
      end
      if (stop_m) return e;
      k += STEP;
      if (k > LIMIT) return e;
    end
    return e;
  endfunction

  function automatic logic [7:0] good_byte();
`ifdef ARC4_SWEEP_LOWER_EN
    int r = $urandom_range(0, 26);
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
`else
    return 8'($urandom_range(32, 126));
`endif
  endfunction

  function automatic logic [7:0] bad_byte();
    case ($urandom_range(0, 2))
      0:       return 8'h7F;
      1:       return 8'h0A;
      default: return 8'hC3;
    endcase
  endfunction

  task automatic fill(input int pct_good);
    for (int k = 0; k <= LIMIT; k++) begin
      int l = $urandom_range(1, 10);
      pt_tab[k][0] = 8'(l);
      for (int i = 1; i <= l; i++) pt_tab[k][i] = good_byte();
      if ($urandom_range(0, 99) >= pct_good) pt_tab[k][$urandom_range(1, l)] = bad_byte();
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input int start, input bit stop_m);
    sb.push_back(model(start, stop_m));
    @(negedge clk); en = 1'b1; start_key = KW'(start);
    @(negedge clk); en = 1'b0;
    if (stop_m) begin
      int n = 0;
      while (!arc4_en && n < 200) begin @(negedge clk); n++; end
      stop = 1'b1;
    end
  endtask

  task automatic wait_idle(output int maxa);
    int n = 0;
    maxa = 0;
    while (!rdy && n < 3000) begin
      @(negedge clk);
      if (int'(pt_addr) > maxa) maxa = int'(pt_addr);
      n++;
    end
    if (!rdy) begin
      tests++; fails++;
      $display("FAIL done_timeout: rdy=%0b expected 1", rdy);
    end
    stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic sweep(input int start, input bit stop_m, output int maxa);
    issue(start, stop_m);
    wait_idle(maxa);
  endtask

  // monitor: each rdy rise closes one sweep
  initial begin
    bit   prev_rdy = 1'b1;
    int   pulses = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pulses = 0; prev_rdy = 1'b1;
      end else begin
        if (arc4_en) pulses++;
        if (rdy && !prev_rdy) begin
          if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            chk("key_valid", 32'(key_valid), 32'(e.valid));
            chk("arc4_en_pulses", 32'(pulses), 32'(e.pulses));
            if (e.valid) chk("key", 32'(key), 32'(e.key));
          end
          pulses = 0;
        end
        prev_rdy = rdy;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ma, n;
    rst = 1'b1; en = 1'b0; stop = 1'b0; start_key = '0;
    fill(0);
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_key_valid", 32'(key_valid), 32'd0);
    chk("rst_key", 32'(key), 32'd0);
    chk("rst_arc4_en", 32'(arc4_en), 32'd0);
    chk("rst_arc4_key", 32'(arc4_key), 32'd0);
    chk("rst_pt_addr", 32'(pt_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single hit on key 3 ("hello")
    fill(0);
    pt_tab[3][0] = 8'd5; pt_tab[3][1] = 8'h68; pt_tab[3][2] = 8'h65;
    pt_tab[3][3] = 8'h6C; pt_tab[3][4] = 8'h6C; pt_tab[3][5] = 8'h6F;
    sweep(0, 1'b0, ma);
    chk("hit_rdy", 32'(rdy), 32'd1);

    // exhaust with wrap: 25,28,31 then 30 alone
    fill(0);
    sweep(25, 1'b0, ma);
    sweep(30, 1'b0, ma);

    // early reject: long message, first byte bad
    fill(0);
    pt_tab[31][0] = 8'd200;
    for (int i = 2; i <= 200; i++) pt_tab[31][i] = 8'h61;
    pt_tab[31][1] = 8'h7F;
    sweep(31, 1'b0, ma);
    chk("early_reject_addr_lt4", 32'(ma < 4), 32'd1);

    // stop after launch: only current key scanned
    fill(0);
    pt_tab[7][0] = 8'd1; pt_tab[7][1] = 8'h61;
    sweep(4, 1'b1, ma);
    fill(100);
    sweep(4, 1'b1, ma);

    // zero-length message accepted
    fill(0);
    pt_tab[9][0] = 8'd0;
    sweep(9, 1'b0, ma);

    // "Hi": accepted only with the full printable set
    fill(0);
    pt_tab[2][0] = 8'd2; pt_tab[2][1] = 8'h48; pt_tab[2][2] = 8'h69;
    sweep(2, 1'b0, ma);

    // reset mid-scan
    fill(100);
    pt_tab[5][0] = 8'd10;
    issue(5, 1'b0);
    n = 0;
    while (pt_addr < 8'd3 && n < 300) begin @(negedge clk); n++; end
    chk("reached_scan", 32'(pt_addr >= 8'd3), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rdy", 32'(rdy), 32'd1);
    chk("midrst_key_valid", 32'(key_valid), 32'd0);
    chk("midrst_arc4_en", 32'(arc4_en), 32'd0);
    chk("midrst_arc4_key", 32'(arc4_key), 32'd0);
    chk("midrst_pt_addr", 32'(pt_addr), 32'd0);
    sb.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    sweep(12, 1'b0, ma);

    // randomized sweeps
    repeat (25) begin
      fill($urandom_range(0, 30));
      sweep($urandom_range(0, LIMIT), $urandom_range(0, 3) == 0, ma);
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
